// File: rtl/door_cell_randomizer.sv
// Keeps a legal, pre-computed grid cell on its outputs; after each Enter rise it
// searches LFSR candidates for a new cell, with a bounded fallback.
module door_cell_randomizer #(
  parameter int          COLS      = 10,
  parameter int          ROWS      = 7,
  parameter logic [15:0] SEED      = 16'hB5A3,
  parameter int          MAX_TRIES = 64
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enter_is_presed,
  output logic [4:0] randum_num1,
  output logic [4:0] randum_num2,
  output logic       cell_valid,
  output logic       busy
);

  typedef enum logic [1:0] {FILL, REFILL, READY} state_t;

  localparam int          CW       = $clog2(MAX_TRIES + 1);
  // An all-zero seed would lock the LFSR, so it is swapped for a known-good one.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [4:0]  FB1_C    = 5'(COLS - 1);
  localparam logic [4:0]  FB2_C    = 5'(COLS - 2);
  localparam logic [4:0]  FB_R     = 5'(ROWS - 1);

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [CW-1:0]   try_q, try_d;
  logic [4:0]      col_q, col_d, row_q, row_d;
  logic            enter_q;

  logic [4:0]      cand_col, cand_row, fb_col;
  logic            rise, in_range, pillar, start_cell, dup, legal, try_last;

  assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign cand_col = lfsr_q[4:0];
  assign cand_row = lfsr_q[9:5];
  assign rise     = enter_is_presed & ~enter_q;

  assign in_range   = (32'(cand_col) < COLS) && (32'(cand_row) < ROWS);
  assign pillar     = cand_col[0] & cand_row[0];
  assign start_cell = (cand_col == 5'd0 && cand_row == 5'd0) ||
                      (cand_col == 5'd1 && cand_row == 5'd0) ||
                      (cand_col == 5'd0 && cand_row == 5'd1);
  assign dup        = (cand_col == col_q) && (cand_row == row_q);
  assign legal      = in_range && !pillar && !start_cell && !((state_q == REFILL) && dup);
  assign try_last   = (try_q == CW'(MAX_TRIES - 1));
  assign fb_col     = (FB1_C == col_q && FB_R == row_q) ? FB2_C : FB1_C;

  always_comb begin
    state_d = state_q;
    try_d   = try_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      FILL, REFILL: begin
        if (legal) begin
          col_d   = cand_col;
          row_d   = cand_row;
          try_d   = '0;
          state_d = READY;
        end else if (try_last) begin
          col_d   = fb_col;
          row_d   = FB_R;
          try_d   = '0;
          state_d = READY;
        end else begin
          try_d   = try_q + CW'(1);
        end
      end
      READY: begin
        if (rise) begin
          try_d   = '0;
          state_d = REFILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= FILL;
      lfsr_q  <= SEED_EFF;
      try_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      enter_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      try_q   <= try_d;
      col_q   <= col_d;
      row_q   <= row_d;
      enter_q <= enter_is_presed;
    end
  end

  // Status comes straight from the state register, so Enter never reaches an output combinationally.
  assign randum_num1 = col_q;
  assign randum_num2 = row_q;
  assign cell_valid  = (state_q == READY);
  assign busy        = (state_q != READY);

endmodule

// File: tb/tb_door_cell_randomizer.sv
// Scoreboarded bench: a press pushes the expected next cell, a negedge monitor pops and checks.
module tb_door_cell_randomizer;

  typedef struct {
    logic [4:0] c;
    logic [4:0] r;
  } cell_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA, rstB, rstC;
  logic       enter0, enter1, enter2;
  logic [4:0] c0, r0, c1, r1, c2, r2, c3, r3;
  logic       v0, b0, v1, b1, v2, b2, v3, b3;

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  cell_t exp_q[$];
  logic [4:0] e_c, e_r;
  logic [15:0] m0, m1;

  door_cell_randomizer u0 (.clk(clk), .resetN(rstA), .enter_is_presed(enter0),
    .randum_num1(c0), .randum_num2(r0), .cell_valid(v0), .busy(b0));
  door_cell_randomizer #(.SEED(16'h001F), .MAX_TRIES(1)) u1 (.clk(clk), .resetN(rstB),
    .enter_is_presed(enter1), .randum_num1(c1), .randum_num2(r1), .cell_valid(v1), .busy(b1));
  door_cell_randomizer #(.SEED(16'h0000)) u2 (.clk(clk), .resetN(rstC), .enter_is_presed(enter2),
    .randum_num1(c2), .randum_num2(r2), .cell_valid(v2), .busy(b2));
  door_cell_randomizer #(.SEED(16'hACE1)) u3 (.clk(clk), .resetN(rstC), .enter_is_presed(enter2),
    .randum_num1(c3), .randum_num2(r3), .cell_valid(v3), .busy(b3));

  function automatic logic [15:0] nxt(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic bit legal(input logic [4:0] c, input logic [4:0] r,
                               input logic [4:0] pc, input logic [4:0] pr, input bit refill);
    return (int'(c) < 10) && (int'(r) < 7) && !(c[0] & r[0]) &&
           !(c == 5'd0 && r == 5'd0) && !(c == 5'd1 && r == 5'd0) && !(c == 5'd0 && r == 5'd1) &&
           !(refill && c == pc && r == pr);
  endfunction

  // Expected accepted cell for a search whose first candidate is l.
  function automatic cell_t search(input logic [15:0] l, input logic [4:0] pc, input logic [4:0] pr,
                                   input bit refill, input int maxt);
    cell_t x;
    for (int t = 0; t < maxt; t++) begin
      x.c = l[4:0];
      x.r = l[9:5];
      if (legal(x.c, x.r, pc, pr, refill)) return x;
      l = nxt(l);
    end
    x.c = (pc == 5'd9 && pr == 5'd6) ? 5'd8 : 5'd9;
    x.r = 5'd6;
    return x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rstA)
    if (!rstA) m0 <= 16'hB5A3; else m0 <= nxt(m0);
  always @(posedge clk or negedge rstB)
    if (!rstB) m1 <= 16'h001F; else m1 <= nxt(m1);

  // Monitor for u0: new cell -> pop and compare; otherwise outputs must hold.
  initial begin
    logic [4:0] lc, lr;
    bit pv, have;
    cell_t e;
    lc = '0; lr = '0; pv = 0; have = 0;
    forever begin
      @(negedge clk);
      if (!rstA) begin
        lc = '0; lr = '0; pv = 0; have = 0;
      end else begin
        chk("busy_vs_valid", int'(b0), int'(!v0));
        if (v0 && !pv) begin
          n_acc++;
          chk("sb_pending", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_col", int'(c0), int'(e.c));
            chk("sb_row", int'(r0), int'(e.r));
          end
          chk("cell_legal_new", int'(legal(c0, r0, lc, lr, have)), 1);
          have = 1;
        end else begin
          chk("hold_col", int'(c0), int'(lc));
          chk("hold_row", int'(r0), int'(lr));
        end
        lc = c0; lr = r0; pv = v0;
      end
    end
  end

  task automatic wait_valid(input int budget, output int cyc);
    cyc = 0;
    while (!v0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_valid", int'(v0), 1);
  endtask

  task automatic press(input int hold);
    int cyc;
    cell_t x;
    wait_valid(200, cyc);
    @(negedge clk);
    x = search(nxt(m0), e_c, e_r, 1, 64);
    exp_q.push_back(x);
    e_c = x.c; e_r = x.r;
    enter0 = 1'b1;
    repeat (hold) @(negedge clk);
    enter0 = 1'b0;
  endtask

  initial begin
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    enter0 = 1'b0; enter1 = 1'b0; enter2 = 1'b0;
    fork
      begin : seq_a
        int cyc, a;
        cell_t x;
        // T1: reset state and first fill
        repeat (3) @(negedge clk);
        chk("rst_col", int'(c0), 0);
        chk("rst_row", int'(r0), 0);
        chk("rst_valid", int'(v0), 0);
        chk("rst_busy", int'(b0), 1);
        x = search(16'hB5A3, 5'd0, 5'd0, 0, 64);
        exp_q.push_back(x);
        e_c = x.c; e_r = x.r;
        rstA = 1'b1;
        wait_valid(200, cyc);
        chk("t1_latency_le64", int'(cyc <= 64), 1);
        // T2: many single-cycle presses
        repeat (1000) press(1);
        wait_valid(200, cyc);
        // T3: Enter held 50 cycles gives exactly one refill
        a = n_acc;
        press(50);
        wait_valid(200, cyc);
        repeat (5) @(negedge clk);
        chk("t3_one_refill", n_acc, a + 1);
        press(1);
        wait_valid(200, cyc);
        repeat (2) @(negedge clk);
        chk("t3_refill_after_release", n_acc, a + 2);
        // T5: reset in the middle of a refill
        @(negedge clk);
        enter0 = 1'b1;
        @(negedge clk);
        enter0 = 1'b0;
        chk("t5_in_refill", int'(v0), 0);
        rstA = 1'b0;
        #1;
        chk("t5_rst_col", int'(c0), 0);
        chk("t5_rst_row", int'(r0), 0);
        chk("t5_rst_valid", int'(v0), 0);
        chk("t5_rst_busy", int'(b0), 1);
        repeat (2) @(negedge clk);
        exp_q.delete();
        x = search(16'hB5A3, 5'd0, 5'd0, 0, 64);
        exp_q.push_back(x);
        e_c = x.c; e_r = x.r;
        rstA = 1'b1;
        wait_valid(200, cyc);
        repeat (3) press(1);
        wait_valid(200, cyc);
        repeat (2) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
      end
      begin : seq_b
        bit found, got;
        logic [15:0] nl;
        cell_t x;
        // T4: MAX_TRIES=1, first candidate (31,0) illegal -> fallback (9,6)
        repeat (3) @(negedge clk);
        rstB = 1'b1;
        @(negedge clk);
        chk("t4_fb1_col", int'(c1), 9);
        chk("t4_fb1_row", int'(r1), 6);
        chk("t4_fb1_valid", int'(v1), 1);
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
          @(negedge clk);
          nl = nxt(m1);
          if (!legal(nl[4:0], nl[9:5], 5'd9, 5'd6, 1)) found = 1;
        end
        chk("t4_illegal_slot_found", int'(found), 1);
        enter1 = 1'b1;
        @(negedge clk);
        enter1 = 1'b0;
        chk("t4_refill", int'(v1), 0);
        @(negedge clk);
        chk("t4_fb2_col", int'(c1), 8);
        chk("t4_fb2_row", int'(r1), 6);
        chk("t4_fb2_valid", int'(v1), 1);
        // T6: SEED=0 must behave exactly like SEED=16'hACE1
        @(negedge clk);
        rstC = 1'b1;
        got = 0;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          chk("t6_col_eq", int'(c2), int'(c3));
          chk("t6_row_eq", int'(r2), int'(r3));
          chk("t6_valid_eq", int'(v2), int'(v3));
          if (v3 && !got) begin
            x = search(16'hACE1, 5'd0, 5'd0, 0, 64);
            chk("t6_first_col", int'(c3), int'(x.c));
            chk("t6_first_row", int'(r3), int'(x.r));
            got = 1;
          end
          enter2 = v3 && !enter2;
        end
        chk("t6_first_seen", int'(got), 1);
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
